calc2_top_core: RTL and testbench

CALC2_TOP_CORE -- requirements
Module: calc2_top

---
 rtl/calc2_top_core.sv | 177 +++++++++++++++++
 tb/tb_calc2_top_core.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc2_top_core.sv
// calc2_top_core: four independent request ports, each feeding a 4-deep FIFO
// of complete two-cycle requests. Two execution units (add/sub/invalid and
// shift) each pick one FIFO head per cycle by round-robin. The result is
// registered onto the granted port's outputs as the entry pops.
// Handshake: no backpressure. A non-zero cmd opens a request, the next cycle
// carries operand2, and a request that finds its FIFO full is silently dropped.
module calc2_top_core (
   input  logic        c_clk,
   input  logic [6:0]  reset,
   input  logic [3:0]  req1_cmd_in,
   input  logic [31:0] req1_data_in,
   input  logic [1:0]  req1_tag_in,
   input  logic [3:0]  req2_cmd_in,
   input  logic [31:0] req2_data_in,
   input  logic [1:0]  req2_tag_in,
   input  logic [3:0]  req3_cmd_in,
   input  logic [31:0] req3_data_in,
   input  logic [1:0]  req3_tag_in,
   input  logic [3:0]  req4_cmd_in,
   input  logic [31:0] req4_data_in,
   input  logic [1:0]  req4_tag_in,
   output logic [1:0]  out_resp1,
   output logic [31:0] out_data1,
   output logic [1:0]  out_tag1,
   output logic [1:0]  out_resp2,
   output logic [31:0] out_data2,
   output logic [1:0]  out_tag2,
   output logic [1:0]  out_resp3,
   output logic [31:0] out_data3,
   output logic [1:0]  out_tag3,
   output logic [1:0]  out_resp4,
   output logic [31:0] out_data4,
   output logic [1:0]  out_tag4
);

   // any reset bit high holds the whole block in reset
   logic rst;
   assign rst = |reset;

   logic [3:0]  cmd_in  [4];
   logic [31:0] data_in [4];
   logic [1:0]  tag_in  [4];
   assign cmd_in[0] = req1_cmd_in;  assign data_in[0] = req1_data_in;  assign tag_in[0] = req1_tag_in;
   assign cmd_in[1] = req2_cmd_in;  assign data_in[1] = req2_data_in;  assign tag_in[1] = req2_tag_in;
   assign cmd_in[2] = req3_cmd_in;  assign data_in[2] = req3_data_in;  assign tag_in[2] = req3_tag_in;
   assign cmd_in[3] = req4_cmd_in;  assign data_in[3] = req4_data_in;  assign tag_in[3] = req4_tag_in;

   // operand1 capture while waiting for operand2
   logic        pend  [4];
   logic [3:0]  p_cmd [4];
   logic [1:0]  p_tag [4];
   logic [31:0] p_op1 [4];

   // per-port FIFO storage and pointers
   logic [3:0]  f_cmd [4][4];
   logic [1:0]  f_tag [4][4];
   logic [31:0] f_op1 [4][4];
   logic [31:0] f_op2 [4][4];
   logic [1:0]  wp  [4];
   logic [1:0]  rp  [4];
   logic [2:0]  cnt [4];

   // registered outputs
   logic [1:0]  resp_q [4];
   logic [31:0] data_q [4];
   logic [1:0]  tag_q  [4];

   // round-robin pointers: the port searched first by each unit
   logic [1:0] ptr_as, ptr_sh;

   logic [3:0]  req_as, req_sh, gnt_as, gnt_sh, pop, wr;
   logic [33:0] head_res [4];

   // result of one request: {resp, data}
   function automatic logic [33:0] exec_op(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      case (cmd)
         4'd1:    exec_op = sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
         4'd2:    exec_op = (a >= b) ? {2'd1, a - b} : {2'd2, 32'd0};
         4'd5:    exec_op = {2'd1, a << b[4:0]};
         4'd6:    exec_op = {2'd1, a >> b[4:0]};
         default: exec_op = {2'd2, 32'd0};
      endcase
   endfunction

   // one-hot grant of the first requester at or after ptr
   function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = 4'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (rr_pick == 4'd0 && req[idx]) rr_pick[idx] = 1'b1;
      end
   endfunction

   // head decode, unit requests, arbitration and FIFO write enables
   always_comb begin
      req_as = 4'd0;
      req_sh = 4'd0;
      wr     = 4'd0;
      for (int p = 0; p < 4; p++) begin
         head_res[p] = exec_op(f_cmd[p][rp[p]], f_op1[p][rp[p]], f_op2[p][rp[p]]);
         if (cnt[p] != 3'd0) begin
            if (f_cmd[p][rp[p]] == 4'd5 || f_cmd[p][rp[p]] == 4'd6) req_sh[p] = 1'b1;
            else                                                   req_as[p] = 1'b1;
         end
         wr[p] = pend[p] && (cnt[p] != 3'd4);
      end
      gnt_as = rr_pick(req_as, ptr_as);
      gnt_sh = rr_pick(req_sh, ptr_sh);
      pop    = gnt_as | gnt_sh;
   end

   // control state: request capture, FIFO pointers, arbitration pointers, outputs
   always_ff @(posedge c_clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < 4; p++) begin
            pend[p]   <= 1'b0;
            p_cmd[p]  <= 4'd0;
            p_tag[p]  <= 2'd0;
            p_op1[p]  <= 32'd0;
            wp[p]     <= 2'd0;
            rp[p]     <= 2'd0;
            cnt[p]    <= 3'd0;
            resp_q[p] <= 2'd0;
            data_q[p] <= 32'd0;
            tag_q[p]  <= 2'd0;
         end
         ptr_as <= 2'd0;
         ptr_sh <= 2'd0;
      end else begin
         for (int p = 0; p < 4; p++) begin
            if (pend[p]) begin
               pend[p] <= 1'b0;
            end else if (cmd_in[p] != 4'd0) begin
               pend[p]  <= 1'b1;
               p_cmd[p] <= cmd_in[p];
               p_tag[p] <= tag_in[p];
               p_op1[p] <= data_in[p];
            end
            if (wr[p])  wp[p] <= wp[p] + 2'd1;
            if (pop[p]) rp[p] <= rp[p] + 2'd1;
            cnt[p] <= cnt[p] + {2'd0, wr[p]} - {2'd0, pop[p]};
            if (pop[p]) begin
               {resp_q[p], data_q[p]} <= head_res[p];
               tag_q[p]               <= f_tag[p][rp[p]];
            end else begin
               resp_q[p] <= 2'd0;
               data_q[p] <= 32'd0;
               tag_q[p]  <= 2'd0;
            end
            if (gnt_as[p]) ptr_as <= 2'(p + 1);
            if (gnt_sh[p]) ptr_sh <= 2'(p + 1);
         end
      end
   end

   // FIFO payload storage; validity is tracked by the pointers above
   always_ff @(posedge c_clk) begin
      for (int p = 0; p < 4; p++) begin
         if (wr[p]) begin
            f_cmd[p][wp[p]] <= p_cmd[p];
            f_tag[p][wp[p]] <= p_tag[p];
            f_op1[p][wp[p]] <= p_op1[p];
            f_op2[p][wp[p]] <= data_in[p];
         end
      end
   end

   assign out_resp1 = resp_q[0];  assign out_data1 = data_q[0];  assign out_tag1 = tag_q[0];
   assign out_resp2 = resp_q[1];  assign out_data2 = data_q[1];  assign out_tag2 = tag_q[1];
   assign out_resp3 = resp_q[2];  assign out_data3 = data_q[2];  assign out_tag3 = tag_q[2];
   assign out_resp4 = resp_q[3];  assign out_data4 = data_q[3];  assign out_tag4 = tag_q[3];

endmodule

// File: tb/tb_calc2_top_core.sv
// Bench for calc2_top_core: directed scenarios plus random traffic, every
// cycle compared against a queue-based transaction model of the block.
module tb_calc2_top_core;

   logic        c_clk = 1'b0;
   logic [6:0]  reset;
   logic [3:0]  cmd    [4];
   logic [31:0] din    [4];
   logic [1:0]  tag    [4];
   logic [1:0]  resp_o [4];
   logic [31:0] data_o [4];
   logic [1:0]  tag_o  [4];
   int n_vec = 0;
   int n_err = 0;

   always #5 c_clk = ~c_clk;

   calc2_top_core dut (
      .c_clk(c_clk), .reset(reset),
      .req1_cmd_in(cmd[0]), .req1_data_in(din[0]), .req1_tag_in(tag[0]),
      .req2_cmd_in(cmd[1]), .req2_data_in(din[1]), .req2_tag_in(tag[1]),
      .req3_cmd_in(cmd[2]), .req3_data_in(din[2]), .req3_tag_in(tag[2]),
      .req4_cmd_in(cmd[3]), .req4_data_in(din[3]), .req4_tag_in(tag[3]),
      .out_resp1(resp_o[0]), .out_data1(data_o[0]), .out_tag1(tag_o[0]),
      .out_resp2(resp_o[1]), .out_data2(data_o[1]), .out_tag2(tag_o[1]),
      .out_resp3(resp_o[2]), .out_data3(data_o[2]), .out_tag3(tag_o[2]),
      .out_resp4(resp_o[3]), .out_data4(data_o[3]), .out_tag4(tag_o[3])
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [3:0]  cmd;
      logic [1:0]  tag;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   req_t        mq [4][$];
   logic        m_pend [4];
   req_t        m_preq [4];
   int          m_ptr  [2];
   logic [1:0]  e_resp [4];
   logic [31:0] e_data [4];
   logic [1:0]  e_tag  [4];

   function automatic int unit_of(input logic [3:0] c);
      return (c == 4'd5 || c == 4'd6) ? 1 : 0;
   endfunction

   task automatic ref_result(input req_t r, output logic [1:0] rs, output logic [31:0] d);
      logic [63:0] s;
      rs = 2'd2;
      d  = 32'd0;
      case (r.cmd)
         4'd1: begin
            s = 64'(r.a) + 64'(r.b);
            if (s <= 64'hFFFF_FFFF) begin rs = 2'd1; d = s[31:0]; end
         end
         4'd2: if (r.a >= r.b) begin rs = 2'd1; d = r.a - r.b; end
         4'd5: begin rs = 2'd1; d = r.a << (r.b % 32); end
         4'd6: begin rs = 2'd1; d = r.a >> (r.b % 32); end
         default: ;
      endcase
   endtask

   task automatic model_reset();
      for (int p = 0; p < 4; p++) begin
         mq[p].delete();
         m_pend[p] = 1'b0;
         e_resp[p] = 2'd0;
         e_data[p] = 32'd0;
         e_tag[p]  = 2'd0;
      end
      m_ptr[0] = 0;
      m_ptr[1] = 0;
   endtask

   // one rising edge: dispatch heads, then accept completed requests
   task automatic model_edge();
      int   sz [4];
      logic g  [4];
      req_t r;
      if (reset != 7'd0) begin
         model_reset();
      end else begin
         for (int p = 0; p < 4; p++) begin
            sz[p] = mq[p].size();
            g[p]  = 1'b0;
            e_resp[p] = 2'd0; e_data[p] = 32'd0; e_tag[p] = 2'd0;
         end
         for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 4; k++) begin
               int p;
               p = (m_ptr[u] + k) % 4;
               if (sz[p] > 0 && unit_of(mq[p][0].cmd) == u) begin
                  g[p] = 1'b1;
                  m_ptr[u] = (p + 1) % 4;
                  break;
               end
            end
         end
         for (int p = 0; p < 4; p++) begin
            if (g[p]) begin
               r = mq[p].pop_front();
               ref_result(r, e_resp[p], e_data[p]);
               e_tag[p] = r.tag;
            end
            if (m_pend[p]) begin
               m_pend[p] = 1'b0;
               m_preq[p].b = din[p];
               if (sz[p] < 4) mq[p].push_back(m_preq[p]);
            end else if (cmd[p] != 4'd0) begin
               m_pend[p] = 1'b1;
               m_preq[p].cmd = cmd[p];
               m_preq[p].tag = tag[p];
               m_preq[p].a   = din[p];
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic check_all();
      for (int p = 0; p < 4; p++) begin
         check_val($sformatf("resp%0d", p + 1), 32'(resp_o[p]), 32'(e_resp[p]));
         check_val($sformatf("data%0d", p + 1), data_o[p], e_data[p]);
         check_val($sformatf("tag%0d",  p + 1), 32'(tag_o[p]),  32'(e_tag[p]));
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge c_clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_all();
      for (int p = 0; p < 4; p++) begin
         cmd[p] = 4'd0;
         din[p] = 32'd0;
         tag[p] = 2'd0;
      end
   endtask

   task automatic reset_pulse();
      reset = 7'd1 << $urandom_range(0, 6);
      #1;
      model_reset();
      check_all();
      tick();
      reset = 7'd0;
   endtask

   // uncontended single request with explicit expected response
   task automatic run_txn(input int p, input logic [3:0] c, input logic [1:0] tg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] er, input logic [31:0] ed);
      idle_all();
      cmd[p] = c; tag[p] = tg; din[p] = a;
      tick();
      cmd[p] = 4'($urandom_range(0, 15)); tag[p] = 2'($urandom_range(0, 3)); din[p] = b;
      tick();
      idle_all();
      tick();
      check_val("txn_resp", 32'(resp_o[p]), 32'(er));
      check_val("txn_data", data_o[p], ed);
      check_val("txn_tag",  32'(tag_o[p]), 32'(tg));
      tick();
      check_val("txn_one_cycle", 32'(resp_o[p]), 32'd0);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 4))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 40));
         3:       return 32'h8000_0000 | 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [3:0] rand_cmd();
      case ($urandom_range(0, 9))
         0, 1, 2, 3: return 4'd0;
         4, 8:       return 4'd1;
         5:          return 4'd2;
         6:          return 4'd5;
         7:          return 4'd6;
         default:    return 4'($urandom_range(0, 15));
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      reset = 7'h7F;
      idle_all();
      model_reset();
      tick();
      tick();
      reset = 7'd0;

      // basic add, overflow/underflow, shifts, invalid command
      run_txn(0, 4'd1, 2'd0, 32'h30, 32'h20, 2'd1, 32'h50);
      run_txn(1, 4'd1, 2'd3, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0);
      run_txn(1, 4'd2, 2'd1, 32'd5, 32'd6, 2'd2, 32'd0);
      run_txn(1, 4'd2, 2'd2, 32'd6, 32'd5, 2'd1, 32'd1);
      run_txn(2, 4'd5, 2'd1, 32'd1, 32'd31, 2'd1, 32'h8000_0000);
      run_txn(2, 4'd6, 2'd2, 32'h8000_0000, 32'h21, 2'd1, 32'h4000_0000);
      run_txn(3, 4'd4, 2'd2, 32'd7, 32'd9, 2'd2, 32'd0);

      // reset between operand1 and operand2 drops the request
      idle_all();
      cmd[0] = 4'd1; din[0] = 32'd3;
      tick();
      din[0] = 32'd4;
      reset_pulse();
      idle_all();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("dropped_by_reset", 32'(resp_o[0]), 32'd0);
      end
      run_txn(0, 4'd1, 2'd1, 32'd100, 32'd23, 2'd1, 32'd123);

      // contention: four adds from a fresh pointer, served 1,2,3,4
      tick();
      reset_pulse();
      idle_all();
      for (int p = 0; p < 4; p++) begin cmd[p] = 4'd1; din[p] = 32'd1; tag[p] = 2'(p); end
      tick();
      idle_all();
      for (int p = 0; p < 4; p++) din[p] = 32'd1;
      tick();
      idle_all();
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("rr_resp", 32'(resp_o[i]), 32'd1);
         check_val("rr_data", data_o[i], 32'd2);
      end
      // three adds plus a shift on port 4: shift is not delayed
      for (int p = 0; p < 3; p++) begin cmd[p] = 4'd1; din[p] = 32'd1; end
      cmd[3] = 4'd5; din[3] = 32'd1;
      tick();
      for (int p = 0; p < 4; p++) din[p] = (p == 3) ? 32'd3 : 32'd1;
      tick();
      idle_all();
      tick();
      check_val("shift_unblocked", data_o[3], 32'd8);
      for (int i = 0; i < 4; i++) tick();

      // flood all ports with adds so FIFOs fill and requests get dropped
      for (int i = 0; i < 60; i++) begin
         for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd1;
            din[p] = 32'($urandom_range(0, 1000));
            tag[p] = 2'($urandom_range(0, 3));
         end
         tick();
      end
      idle_all();
      for (int i = 0; i < 30; i++) tick();

      // random traffic with occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         for (int p = 0; p < 4; p++) begin
            cmd[p] = rand_cmd();
            din[p] = rand_operand();
            tag[p] = 2'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 299) == 0) reset_pulse();
         else                             tick();
      end
      idle_all();
      for (int i = 0; i < 30; i++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
